// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock programmable FIFO: width derivation and
// reset values of the registered status flags.
package sync_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam logic RST_RVALID     = 1'b0;
    localparam logic RST_WFULL      = 1'b0;
    localparam logic RST_REMPTY     = 1'b1;
    localparam logic RST_PROG_FULL  = 1'b0;
    localparam logic RST_PROG_EMPTY = 1'b1;
    localparam logic RST_ERR        = 1'b0;

endpackage

// File: rtl/sync_fifo_wrap_ptr.sv
// Modulo-DEPTH binary pointer with increment enable; wraps DEPTH-1 -> 0 so
// non-power-of-two depths need no extra address translation.
module sync_fifo_wrap_ptr
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = 48,
    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO, arbitrary depth, exact count and programmable watermarks.
// Sticky overflow/underflow flags exist only when SYNC_FIFO_PROG_ERR_EN is defined.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int DEPTH = 48,
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wreq,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rreq,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic [CW-1:0]    number,
    input  logic [CW-1:0]    prog_full_thresh,
    input  logic [CW-1:0]    prog_empty_thresh,
    output logic             prog_full,
    output logic             prog_empty,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CW-1:0]    number_nxt;

    // A push into a full FIFO rides on a same-cycle pop; a pop never falls through.
    assign pop_ok  = rreq & ~rempty;
    assign push_ok = wreq & (~wfull | pop_ok);

    always_comb begin
        number_nxt = number;
        case ({push_ok, pop_ok})
            2'b10:   number_nxt = number + 1'b1;
            2'b01:   number_nxt = number - 1'b1;
            default: number_nxt = number;
        endcase
    end

    sync_fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push_ok),
        .ptr   (wptr)
    );

    sync_fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop_ok),
        .ptr   (rptr)
    );

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Flags are loaded from the next count so they move on the same edge as number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata      <= '0;
            rvalid     <= RST_RVALID;
            number     <= '0;
            wfull      <= RST_WFULL;
            rempty     <= RST_REMPTY;
            prog_full  <= RST_PROG_FULL;
            prog_empty <= RST_PROG_EMPTY;
        end else begin
            number     <= number_nxt;
            wfull      <= (number_nxt == CW'(DEPTH));
            rempty     <= (number_nxt == '0);
            prog_full  <= (number_nxt >= prog_full_thresh);
            prog_empty <= (number_nxt <= prog_empty_thresh);
            rvalid     <= pop_ok;
            if (pop_ok) begin
                rdata <= mem[rptr];
            end
        end
    end

`ifdef SYNC_FIFO_PROG_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= RST_ERR;
            underflow <= RST_ERR;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wreq & wfull & ~pop_ok) overflow  <= 1'b1;
            if (rreq & rempty)          underflow <= 1'b1;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: a queue-based reference model predicts
// status and read data; a monitor compares them after every clock edge.
module tb_sync_fifo_prog;

    localparam int DSIZE = 32;
    localparam int DEPTH = 48;
    localparam int CW    = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wreq = 1'b0;
    logic             rreq = 1'b0;
    logic             err_clr = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic [DSIZE-1:0] rdata;
    logic             rvalid, wfull, rempty, prog_full, prog_empty, overflow, underflow;
    logic [CW-1:0]    number;
    logic [CW-1:0]    prog_full_thresh = '0;
    logic [CW-1:0]    prog_empty_thresh = '0;

    sync_fifo_prog #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wreq              (wreq),
        .wdata             (wdata),
        .rreq              (rreq),
        .rdata             (rdata),
        .rvalid            (rvalid),
        .wfull             (wfull),
        .rempty            (rempty),
        .number            (number),
        .prog_full_thresh  (prog_full_thresh),
        .prog_empty_thresh (prog_empty_thresh),
        .prog_full         (prog_full),
        .prog_empty        (prog_empty),
        .err_clr           (err_clr),
        .overflow          (overflow),
        .underflow         (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int number;
        bit wfull, rempty, pf, pe, rvalid, ovf, udf;
    } stat_t;

    stat_t            stat_q[$];
    logic [DSIZE-1:0] model_q[$];
    logic [DSIZE-1:0] exp_q[$];
    logic [DSIZE-1:0] last_rdata = '0;
    int               pft_next = 0;
    int               pet_next = 0;
    bit               m_ovf = 1'b0;
    bit               m_udf = 1'b0;
    int               checks = 0;
    int               fails = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic set_thresh(input int pf, input int pe);
        pft_next = pf;
        pet_next = pe;
    endtask

    // One clock of stimulus; the model predicts what the following edge produces.
    task automatic cycle(input bit w, input logic [DSIZE-1:0] d, input bit r, input bit clr);
        int    cnt;
        bit    pop, push;
        stat_t s;
        @(negedge clk);
        wreq = w; wdata = d; rreq = r; err_clr = clr;
        prog_full_thresh  = CW'(pft_next);
        prog_empty_thresh = CW'(pet_next);
        cnt  = model_q.size();
        pop  = r && (cnt > 0);
        push = w && ((cnt < DEPTH) || pop);
        if (pop)  exp_q.push_back(model_q.pop_front());
        if (push) model_q.push_back(d);
`ifdef SYNC_FIFO_PROG_ERR_EN
        if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && (cnt == DEPTH) && !pop) m_ovf = 1'b1;
            if (r && (cnt == 0))             m_udf = 1'b1;
        end
`endif
        s.number = model_q.size();
        s.wfull  = (s.number == DEPTH);
        s.rempty = (s.number == 0);
        s.pf     = (s.number >= pft_next);
        s.pe     = (s.number <= pet_next);
        s.rvalid = pop;
        s.ovf    = m_ovf;
        s.udf    = m_udf;
        stat_q.push_back(s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wreq = 1'b0; rreq = 1'b0; err_clr = 1'b0;
        model_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        last_rdata = '0;
        #1;
        check("rst_async_number", number, 0);
        check("rst_async_rempty", rempty, 1);
        check("rst_async_prog_empty", prog_empty, 1);
        check("rst_async_rvalid", rvalid, 0);
        check("rst_async_wfull", wfull, 0);
        check("rst_async_prog_full", prog_full, 0);
        check("rst_async_overflow", overflow, 0);
        check("rst_async_underflow", underflow, 0);
        @(posedge clk);
        #2;
        check("rst_number", number, 0);
        check("rst_rempty", rempty, 1);
        check("rst_prog_empty", prog_empty, 1);
        check("rst_rvalid", rvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare status and any returned word shortly after each edge.
    initial begin
        stat_t            s;
        logic [DSIZE-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("number", number, s.number);
                check("wfull", wfull, s.wfull);
                check("rempty", rempty, s.rempty);
                check("prog_full", prog_full, s.pf);
                check("prog_empty", prog_empty, s.pe);
                check("rvalid", rvalid, s.rvalid);
                check("overflow", overflow, s.ovf);
                check("underflow", underflow, s.udf);
            end
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL rdata_unexpected: got word %0h expected no pop at %0t", rdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", rdata, e);
                    last_rdata = e;
                end
            end else begin
                check("rdata_hold", rdata, last_rdata);
            end
        end
    end

    initial begin
        int pw;
        do_reset();
        set_thresh(40, 4);

        // Offset the pointers by one so the wrap lands mid-burst.
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < DEPTH; i++) cycle(1'b1, DSIZE'(i), 1'b0, 1'b0);
            cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
            for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Full with simultaneous push/pop.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Empty with simultaneous push/pop.
        cycle(1'b1, 32'h0000_0011, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Lower the almost-full watermark under an occupancy of 35.
        for (int i = 0; i < 35; i++) cycle(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
        set_thresh(30, 4);
        cycle(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 35; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        set_thresh(40, 4);

        // Error flags: underflow, overflow, and clear racing a new overflow.
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 32'hBAD0_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'hBAD0_0002, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Reset in the middle of a burst at count 17.
        for (int i = 0; i < 17; i++) cycle(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
        do_reset();

        // Randomized traffic with drifting fill bias and watermarks.
        pw = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) pw = $urandom_range(20, 80);
            if (i % 100 == 0) set_thresh($urandom_range(0, 63), $urandom_range(0, 63));
            cycle(($urandom_range(0, 99) < pw), DSIZE'($urandom),
                  ($urandom_range(0, 99) < (100 - pw)), ($urandom_range(0, 49) == 0));
        end

        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("pending_reads", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
